// File: rtl/mdu_hilo.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations, result written in FIX.
module mdu_hilo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_div_zero;
  logic [4:0]  r_cnt;
  logic [31:0] r_opb;
  logic [31:0] r_a_raw;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_msum;
  logic [63:0] w_mul_next;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_rem_sub;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  // op[0] clear selects the signed variants; their operands iterate as magnitudes.
  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed & operand_a[31]) ? (32'd0 - operand_a) : operand_a;
  assign w_abs_b  = (w_signed & operand_b[31]) ? (32'd0 - operand_b) : operand_b;

  // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in.
  assign w_msum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_next = {w_msum, r_acc[31:1]};

  // Divide: remainder in acc[63:32], dividend bits shift up from acc[31:0] while
  // quotient bits fill in from the bottom. The subtracted value always fits 32 bits.
  assign w_trial    = {r_acc[63:32], r_acc[31]};
  assign w_ge       = (w_trial >= {1'b0, r_opb});
  assign w_rem_sub  = w_trial[31:0] - r_opb;
  assign w_div_next = w_ge ? {w_rem_sub, r_acc[30:0], 1'b1}
                           : {w_trial[31:0], r_acc[30:0], 1'b0};

  assign w_prod = (r_sign_a ^ r_sign_b) ? (64'd0 - r_acc) : r_acc;
  assign w_quot = (r_sign_a ^ r_sign_b) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem  = r_sign_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_op[1]) begin
      if (r_div_zero) begin
        w_res_hi = r_a_raw;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 2'd0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= 5'd0;
      r_opb      <= 32'd0;
      r_a_raw    <= 32'd0;
      r_acc      <= 64'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_CALC;
            r_op       <= op;
            r_sign_a   <= w_signed & operand_a[31];
            r_sign_b   <= w_signed & operand_b[31];
            r_div_zero <= op[1] & (operand_b == 32'd0);
            r_cnt      <= 5'd0;
            r_opb      <= w_abs_b;
            r_a_raw    <= operand_a;
            r_acc      <= {32'd0, w_abs_a};
          end else begin
            if (mthi) r_hi <= wr_data;
            if (mtlo) r_lo <= wr_data;
          end
        end
        S_CALC: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_op[1] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!cancel) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS32 core. It sits directly downstream of the register file and consumes rs/rt operand values (read_data1/read_data2) for MULT, MULTU, DIV and DIVU. Results are held in HI/LO, which MFHI/MFLO read. MTHI/MTLO write HI/LO directly.

## Interface
- No parameters. The datapath is fixed at 32 bits and takes 32 iteration cycles.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  in  32  rs value (multiplicand / dividend).
- operand_b  in  32  rt value (multiplier / divisor).
- mthi  in  1  write wr_data into HI; honoured only in IDLE.
- mtlo  in  1  write wr_data into LO; honoured only in IDLE.
- wr_data  in  32  data for MTHI/MTLO.
- cancel  in  1  pipeline flush; aborts the operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result while it is high.

## Operation
- States: IDLE, CALC, FIX.
- IDLE -> CALC: start=1. At that edge, op, operand signs, absolute operand magnitudes (signed ops only) and the divisor-zero flag are latched, and the iteration counter is cleared.
- CALC: one iteration per cycle. MULT/MULTU use radix-2 shift-add into a 64-bit accumulator. DIV/DIVU use radix-2 restoring division into a 64-bit remainder/quotient register. After 32 iterations, CALC -> FIX.
- FIX -> IDLE: write the result to hi/lo and pulse done.
  - Multiply result: hi = product[63:32], lo = product[31:0].
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Divide result: lo = quotient, hi = remainder.
  - Signed divide: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero (operand_b=0, DIV or DIVU): lo = 32'hFFFF_FFFF, hi = operand_a as latched. The latency is unchanged.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF gives lo = 32'h8000_0000, hi = 0, with no trap.
- cancel=1 in CALC or FIX: the next state is IDLE, hi/lo are unchanged and no done pulse is produced. cancel in IDLE has no effect.
- start while busy is ignored. mthi/mtlo while busy are ignored.
- start together with mthi/mtlo in IDLE: start wins and the move is dropped.
- mthi and mtlo in the same IDLE cycle: both registers are written.
- busy = (state != IDLE), decoded from the state register.
- hi/lo outputs are always the architectural registers; intermediate values are never visible.

## Timing
- Reset (asynchronous, immediate): state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0. Reset mid-operation discards all work.
- Let E0 be the edge that samples start. After E0, busy = 1.
- Edges E1..E32 perform iterations 1..32. At E32, CALC -> FIX.
- At E33, hi/lo are loaded, done = 1 for one cycle, and the state returns to IDLE with busy = 0.
- Total: 33 cycles from start to result; every op, including divide by zero, has the same latency.
- A new start may be presented in the cycle in which done is high; it is sampled at E34.
- MTHI/MTLO: hi/lo are updated at the edge that samples the strobe, so they are visible 1 cycle later.
- done is a registered output. busy is decoded from registered state only, with no combinational path from inputs.

## Test plan
- MULT a = 32'hFFFF_FFFD (-3), b = 7 -> done at E33 with hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFEB.
- MULTU a = b = 32'hFFFF_FFFF -> hi = 32'hFFFF_FFFE, lo = 32'h0000_0001.
- DIV a = -7, b = 2 -> lo = 32'hFFFF_FFFD, hi = 32'hFFFF_FFFF.
  - DIVU a = 100, b = 7 -> lo = 14, hi = 2.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo = 32'h8000_0000, hi = 0.
- Divide by zero: DIVU a = 5, b = 0 -> lo = 32'hFFFF_FFFF, hi = 5, after the same 33-cycle latency.
- Interference:
  - Set hi = 32'h1234_5678 via mthi.
  - Start MULT; pulse mthi and start during CALC -> both ignored.
  - Assert cancel at iteration 10 -> IDLE, no done, hi still 32'h1234_5678.
- Reset: assert rst_n = 0 mid-DIV, between clock edges -> hi = lo = 0 and busy = 0 immediately. After release, start DIVU 9/3 -> lo = 3, hi = 0, done at E33.
